// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the byte-serial 16-bit ALU sequencer.
// Holds the request opcode encoding, the FSM states and the 8-bit ALU commands.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        OP_ADD16 = 2'b00,
        OP_SHL16 = 2'b01,
        OP_XOR16 = 2'b10,
        OP_AND16 = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b000,
        ST_LO   = 3'b001,
        ST_HI   = 3'b010,
        ST_CI   = 3'b011,
        ST_DONE = 3'b100
    } state_e;

    localparam logic [2:0] ALU_CMD_ADD = 3'b000;
    localparam logic [2:0] ALU_CMD_SHL = 3'b001;
    localparam logic [2:0] ALU_CMD_XOR = 3'b011;
    localparam logic [2:0] ALU_CMD_AND = 3'b100;

    function automatic logic [2:0] cmd_for_op(input op_e op);
        logic [2:0] cmd;
        case (op)
            OP_ADD16: cmd = ALU_CMD_ADD;
            OP_SHL16: cmd = ALU_CMD_SHL;
            OP_XOR16: cmd = ALU_CMD_XOR;
            OP_AND16: cmd = ALU_CMD_AND;
            default:  cmd = ALU_CMD_ADD;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/alu_seq_alu8.sv
// Combinational 8-bit ALU; SHL shifts sc_i into bit 0 and reports bit 7 as carry.
// Unused command codes produce zero result and zero carry.
module alu_seq_alu8
    import alu_seq_pkg::*;
(
    input  logic [2:0] cmd_i,
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       sc_i,
    output logic [7:0] y_o,
    output logic       co_o
);

    // Command decode and datapath
    always_comb begin
        y_o  = 8'h00;
        co_o = 1'b0;
        case (cmd_i)
            ALU_CMD_ADD: {co_o, y_o} = {1'b0, a_i} + {1'b0, b_i};
            ALU_CMD_SHL: {co_o, y_o} = {a_i, sc_i};
            ALU_CMD_XOR: y_o = a_i ^ b_i;
            ALU_CMD_AND: y_o = a_i & b_i;
            default: begin
                y_o  = 8'h00;
                co_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// 16-bit ALU built by sequencing one 8-bit ALU over the low byte, the high byte
// and, for ADD16, a carry-propagation pass; valid/ready on both sides.
module alu_seq
    import alu_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_carry,
    output logic        rsp_zero
);

    state_e      state_q, state_d;
    op_e         op_q, op_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [7:0]  lo_q, lo_d;
    logic [7:0]  hi_q, hi_d;
    logic        clo_q, clo_d;
    logic        carry_q, carry_d;

    logic        req_ready_q;
    logic        rsp_valid_q;
    logic [15:0] rsp_data_q;
    logic        rsp_carry_q;
    logic        rsp_zero_q;

    logic [2:0]  alu_cmd_s;
    logic [7:0]  alu_a_s;
    logic [7:0]  alu_b_s;
    logic        alu_sc_s;
    logic [7:0]  alu_y_s;
    logic        alu_co_s;

    alu_seq_alu8 u_alu8 (
        .cmd_i (alu_cmd_s),
        .a_i   (alu_a_s),
        .b_i   (alu_b_s),
        .sc_i  (alu_sc_s),
        .y_o   (alu_y_s),
        .co_o  (alu_co_s)
    );

    // Next-state, operand latching and ALU drive
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        clo_d     = clo_q;
        carry_d   = carry_q;
        alu_cmd_s = cmd_for_op(op_q);
        alu_a_s   = 8'h00;
        alu_b_s   = 8'h00;
        alu_sc_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d    = op_e'(req_op);
                    a_d     = req_a;
                    b_d     = req_b;
                    lo_d    = 8'h00;
                    hi_d    = 8'h00;
                    clo_d   = 1'b0;
                    carry_d = 1'b0;
                    state_d = ST_LO;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LO: begin
                alu_a_s = a_q[7:0];
                alu_b_s = b_q[7:0];
                lo_d    = alu_y_s;
                clo_d   = alu_co_s;
                state_d = ST_HI;
            end
            ST_HI: begin
                alu_a_s = a_q[15:8];
                alu_b_s = b_q[15:8];
                // Only the shift chains the low byte's carry into the high byte here;
                // ADD16 propagates it in the separate CI pass.
                if (op_q == OP_SHL16) begin
                    alu_sc_s = clo_q;
                end else begin
                    alu_sc_s = 1'b0;
                end
                hi_d = alu_y_s;
                if (op_q == OP_ADD16 || op_q == OP_SHL16) begin
                    carry_d = alu_co_s;
                end else begin
                    carry_d = 1'b0;
                end
                if (op_q == OP_ADD16) begin
                    state_d = ST_CI;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_CI: begin
                alu_cmd_s = ALU_CMD_ADD;
                alu_a_s   = hi_q;
                alu_b_s   = {7'h00, clo_q};
                hi_d      = alu_y_s;
                carry_d   = carry_q | alu_co_s;
                state_d   = ST_DONE;
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, operand and partial-result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_ADD16;
            a_q     <= 16'h0000;
            b_q     <= 16'h0000;
            lo_q    <= 8'h00;
            hi_q    <= 8'h00;
            clo_q   <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            clo_q   <= clo_d;
            carry_q <= carry_d;
        end
    end

    // Registered handshake and response outputs, decoded from the next state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 16'h0000;
            rsp_carry_q <= 1'b0;
            rsp_zero_q  <= 1'b0;
        end else begin
            req_ready_q <= (state_d == ST_IDLE);
            rsp_valid_q <= (state_d == ST_DONE);
            if (state_d == ST_DONE) begin
                rsp_data_q  <= {hi_d, lo_d};
                rsp_carry_q <= carry_d;
                rsp_zero_q  <= ({hi_d, lo_d} == 16'h0000);
            end else begin
                rsp_data_q  <= 16'h0000;
                rsp_carry_q <= 1'b0;
                rsp_zero_q  <= 1'b0;
            end
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_carry = rsp_carry_q;
    assign rsp_zero  = rsp_zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed corner cases plus random operations
// compared against an arithmetic reference model.
module tb_alu_seq;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_carry;
    logic        rsp_zero;

    int n_cmp;
    int n_fail;

    alu_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_carry (rsp_carry),
        .rsp_zero  (rsp_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result: {carry, data} from plain 16-bit arithmetic.
    function automatic logic [16:0] ref_model(input logic [1:0] op, input logic [15:0] a,
                                              input logic [15:0] b);
        case (op)
            2'b00:   return {1'b0, a} + {1'b0, b};
            2'b01:   return {1'b0, a} * 17'd2;
            2'b10:   return {1'b0, a ^ b};
            default: return {1'b0, a & b};
        endcase
    endfunction

    function automatic int ref_latency(input logic [1:0] op);
        return (op == 2'b00) ? 4 : 3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered at the negedge after acceptance (cycle 1); returns at the negedge
    // after the response handshake.
    task automatic wait_rsp(input string tag, input int lat, input logic [16:0] exp,
                            input int hold, input bit junk, input bit keep_valid);
        int k;
        k = 1;
        while (rsp_valid !== 1'b1 && k < 12) begin
            chk({tag, "_busy_ready"}, {31'd0, req_ready}, 32'd0);
            chk({tag, "_idle_data"}, {16'd0, rsp_data}, 32'd0);
            chk({tag, "_idle_flags"}, {30'd0, rsp_carry, rsp_zero}, 32'd0);
            if (junk) begin
                req_valid = 1'($urandom);
                req_op    = 2'($urandom);
                req_a     = 16'($urandom);
                req_b     = 16'($urandom);
            end
            @(negedge clk);
            k++;
        end
        chk({tag, "_latency"}, k, lat);
        chk({tag, "_data"}, {16'd0, rsp_data}, {16'd0, exp[15:0]});
        chk({tag, "_carry"}, {31'd0, rsp_carry}, {31'd0, exp[16]});
        chk({tag, "_zero"}, {31'd0, rsp_zero}, {31'd0, (exp[15:0] == 16'h0000)});
        for (int i = 0; i < hold; i++) begin
            chk({tag, "_hold_valid"}, {31'd0, rsp_valid}, 32'd1);
            chk({tag, "_hold_data"}, {16'd0, rsp_data}, {16'd0, exp[15:0]});
            chk({tag, "_hold_flags"}, {30'd0, rsp_carry, rsp_zero},
                {30'd0, exp[16], (exp[15:0] == 16'h0000)});
            chk({tag, "_hold_ready"}, {31'd0, req_ready}, 32'd0);
            req_valid = 1'b1;
            req_op    = 2'($urandom);
            req_a     = 16'($urandom);
            req_b     = 16'($urandom);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        if (!keep_valid) req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_post_valid"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, "_post_ready"}, {31'd0, req_ready}, 32'd1);
        chk({tag, "_post_data"}, {16'd0, rsp_data}, 32'd0);
    endtask

    task automatic do_op(input string tag, input logic [1:0] op, input logic [15:0] a,
                         input logic [15:0] b, input int hold);
        chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        rsp_ready = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        wait_rsp(tag, ref_latency(op), ref_model(op, a, b), hold, 1'b1, 1'b0);
    endtask

    initial begin
        logic [1:0]  r_op;
        logic [15:0] r_a;
        logic [15:0] r_b;
        n_cmp     = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_a     = 16'h0000;
        req_b     = 16'h0000;
        rsp_ready = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_data", {16'd0, rsp_data}, 32'd0);
        chk("rst_flags", {30'd0, rsp_carry, rsp_zero}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op("add_00ff", 2'b00, 16'h00FF, 16'h0001, 0);
        do_op("add_ffff", 2'b00, 16'hFFFF, 16'h0001, 0);
        do_op("shl_8080", 2'b01, 16'h8080, 16'h1234, 0);
        do_op("xor_hold", 2'b10, 16'h5AA5, 16'h5AA5, 5);
        do_op("and_ffff", 2'b11, 16'hFFFF, 16'hA5C3, 1);

        // Reset in HI aborts an AND16 with no response.
        req_valid = 1'b1;
        req_op    = 2'b11;
        req_a     = 16'hF0F0;
        req_b     = 16'h3C3C;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_ready", {31'd0, req_ready}, 32'd1);
        chk("abort_valid", {31'd0, rsp_valid}, 32'd0);
        chk("abort_data", {16'd0, rsp_data}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
            @(negedge clk);
        end
        do_op("add_after_rst", 2'b00, 16'h0001, 16'h0002, 0);

        // Back-to-back ADD16 then XOR16 with req_valid held high.
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_a     = 16'h1234;
        req_b     = 16'hEDCC;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_op = 2'b10;
        req_a  = 16'hA5A5;
        req_b  = 16'h0FF0;
        wait_rsp("b2b_add", 4, ref_model(2'b00, 16'h1234, 16'hEDCC), 0, 1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        chk("b2b_accept", {31'd0, req_ready}, 32'd0);
        req_valid = 1'b0;
        wait_rsp("b2b_xor", 3, ref_model(2'b10, 16'hA5A5, 16'h0FF0), 0, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            r_op = 2'($urandom);
            r_a  = 16'($urandom);
            r_b  = 16'($urandom);
            if (n % 8 == 0) r_b = 16'h0000 - r_a;
            do_op("rand", r_op, r_a, r_b, int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 clk  input  1  single clock; all state updates on the rising edge.
REQ-002 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-003 req_valid  input  1  requester presents an operation.
REQ-004 req_ready  output  1  sequencer can accept an operation.
REQ-005 req_op  input  2  operation select: 00 ADD16, 01 SHL16, 10 XOR16, 11 AND16.
REQ-006 req_a  input  16  operand A.
REQ-007 req_b  input  16  operand B.
REQ-008 rsp_valid  output  1  result is available.
REQ-009 rsp_ready  input  1  consumer accepts the result.
REQ-010 rsp_data  output  16  16-bit result.
REQ-011 rsp_carry  output  1  carry out of bit 15 (ADD16, SHL16); 0 for XOR16 and AND16.
REQ-012 rsp_zero  output  1  1 when rsp_data == 16'h0000.

Function
REQ-013 The block SHALL perform 16-bit operations by sequencing a single 8-bit ALU instance, low byte first, one ALU operation per cycle.
REQ-014 FSM states SHALL be IDLE, LO, HI, CI and DONE.
REQ-015 req_ready SHALL be 1 only in IDLE.
- A request is accepted when req_valid && req_ready.
- On acceptance, op, A and B are latched and the FSM goes IDLE->LO.
REQ-016 LO SHALL drive the ALU with the low bytes and capture the low result byte and ALU carry-out.
- ALU commands: ADD 000, SHL 001 with sc_i=0, XOR 011, AND 100.
- Next state: HI.
REQ-017 HI SHALL drive the ALU with the high bytes and the same command, and capture the high result byte.
- SHL16 feeds the captured low carry into sc_i; all other operations use sc_i=0.
- ADD16 goes to CI; all other operations go to DONE.
REQ-018 CI (ADD16 only) SHALL add 8'h01 to the high result when the low carry is 1, or 8'h00 otherwise (ALU cmd 000).
- rsp_carry = (HI carry) OR (CI carry).
- Next state: DONE.
REQ-019 For SHL16, rsp_carry SHALL be the ALU carry-out captured in HI (original A[15]).
REQ-020 Latency from the acceptance edge to rsp_valid high:
- 3 cycles for SHL16, XOR16 and AND16.
- 4 cycles for ADD16.
REQ-021 In DONE, rsp_valid SHALL be 1, and rsp_data, rsp_carry and rsp_zero SHALL hold stable until rsp_ready is 1; the FSM then returns to IDLE on that edge.
REQ-022 Back-to-back operation: req_ready SHALL rise in the cycle after the rsp handshake, so no request is accepted in the same cycle a response completes.
REQ-023 req_valid, req_op, req_a and req_b SHALL be ignored outside IDLE; latched operands SHALL NOT change mid-operation.
REQ-024 Wrap-around:
- ADD16 sums SHALL wrap modulo 2^16, with the overflow reported only on rsp_carry.
- SHL16 SHALL shift in 0 at bit 0.
REQ-025 rsp_data, rsp_carry and rsp_zero SHALL be 0 whenever rsp_valid is 0.

Reset
REQ-026 With rst_n low at a clock edge, the FSM SHALL enter IDLE and clear all latched operands, partial results and carries.
REQ-027 Outputs during and after reset: req_ready=1, rsp_valid=0, rsp_data=0, rsp_carry=0, rsp_zero=0.
REQ-028 Reset asserted in any non-IDLE state SHALL abort the operation with no response issued; the next request after reset SHALL be processed normally.

Structure
REQ-029 A shared package SHALL hold:
- the req_op encoding typedef (2-bit enum);
- the FSM state typedef;
- the ALU command constants ADD, SHL, XOR and AND (3-bit).
REQ-030 The existing 8-bit ALU SHALL be the one sub-module, instantiated once; the sequencer drives its command, operands and sc_i combinationally from the current state.

Verification
REQ-031 ADD16 A=16'h00FF, B=16'h0001, rsp_ready held 1 -> rsp_data=16'h0100, rsp_carry=0, rsp_zero=0; rsp_valid exactly 4 cycles after acceptance.
REQ-032 ADD16 A=16'hFFFF, B=16'h0001 -> rsp_data=16'h0000, rsp_carry=1, rsp_zero=1.
REQ-033 SHL16 A=16'h8080 -> rsp_data=16'h0100, rsp_carry=1; rsp_valid 3 cycles after acceptance.
REQ-034 XOR16 A=16'h5AA5, B=16'h5AA5 with rsp_ready held 0 for 5 cycles -> rsp_valid, rsp_data=0 and rsp_zero=1 held stable; req_ready stays 0; new req_valid is ignored until the handshake.
REQ-035 AND16 A=16'hF0F0, B=16'h3C3C accepted, rst_n pulled low in the HI state -> no rsp_valid; req_ready=1 after reset; the next ADD16 1+2 returns 16'h0003.
REQ-036 Back-to-back ADD16 then XOR16 with req_valid held high -> the second acceptance occurs one cycle after the first rsp handshake, and both results are correct.
